// File: rtl/pe_pkg.sv
// Shared definitions for the vector PE: mode encodings, the saturating add
// result payload and width helpers.
package pe_pkg;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Working width for psum/dot arithmetic before clamping or wrapping to PSUM_WIDTH.
  localparam int unsigned SUM_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [SUM_W-1:0] val;
  } sat_res_t;

  // Width of a LANES-wide sum of 2*DATA_WIDTH products.
  function automatic int unsigned dot_width(int unsigned data_width, int unsigned lanes);
    return 2 * data_width + int'($clog2(lanes));
  endfunction

  // Adds two SUM_W-extended operands and clamps to the width-bit range.
  // val holds the clamped sum; ovf flags that clamping happened.
  function automatic sat_res_t sat_add(logic [SUM_W-1:0] a, logic [SUM_W-1:0] b,
                                       logic signed_en, int unsigned width);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] hi;
    logic [SUM_W-1:0] lo;
    sat_res_t         r;
    sum   = a + b;
    r.ovf = 1'b0;
    r.val = sum;
    if (signed_en) begin
      hi = (SUM_W'(1) << (width - 1)) - SUM_W'(1);
      lo = ~hi;
      if ($signed(sum) > $signed(hi)) begin
        r.ovf = 1'b1;
        r.val = hi;
      end else if ($signed(sum) < $signed(lo)) begin
        r.ovf = 1'b1;
        r.val = lo;
      end
    end else begin
      hi = (SUM_W'(1) << width) - SUM_W'(1);
      if (sum > hi) begin
        r.ovf = 1'b1;
        r.val = hi;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_vec_if.sv
// Neighbour link of the systolic array: ifmap, weight and psum streams with
// their enables. master drives a link, slave receives it.
interface pe_vec_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned PSUM_WIDTH = 32
) ();

  logic [LANES*DATA_WIDTH-1:0] ifmap;
  logic                        ifmap_en;
  logic [LANES*DATA_WIDTH-1:0] weight;
  logic                        weight_en;
  logic [PSUM_WIDTH-1:0]       psum;
  logic                        psum_en;

  modport master (output ifmap, ifmap_en, weight, weight_en, psum, psum_en);
  modport slave  (input  ifmap, ifmap_en, weight, weight_en, psum, psum_en);

endinterface

// File: rtl/pe_dot.sv
// Combinational LANES-wide dot product.
// a_i, b_i : packed vectors, lane 0 in LSBs
// dot_c    : sum of lane products, sign/zero-extended per SIGNED
module pe_dot
  import pe_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned LANES      = 4,
  parameter  int unsigned SIGNED     = 1,
  localparam int unsigned DOT_W      = dot_width(DATA_WIDTH, LANES)
) (
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  output logic [DOT_W-1:0]            dot_c
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam logic        SGN    = (SIGNED != 0);

  // Operands are extended to PROD_W first, so the low PROD_W bits of the
  // unsigned product equal the signed product when SGN is set.
  always_comb begin
    logic [DATA_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] eb;
    logic [PROD_W-1:0]     xa;
    logic [PROD_W-1:0]     xb;
    logic [PROD_W-1:0]     prod;
    dot_c = '0;
    ea    = '0;
    eb    = '0;
    xa    = '0;
    xb    = '0;
    prod  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      ea    = a_i[k*DATA_WIDTH +: DATA_WIDTH];
      eb    = b_i[k*DATA_WIDTH +: DATA_WIDTH];
      xa    = {{DATA_WIDTH{SGN & ea[DATA_WIDTH-1]}}, ea};
      xb    = {{DATA_WIDTH{SGN & eb[DATA_WIDTH-1]}}, eb};
      prod  = xa * xb;
      dot_c = dot_c + {{(DOT_W-PROD_W){SGN & prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/pe_vec.sv
// Vector processing element: double-buffered stationary ifmap, LANES-wide MAC,
// PASS (psum_o = psum_i + dot) and ACC (local accumulator, drained on demand).
// clk, rst : clock, synchronous active-high reset
// up       : upstream link (ifmap/weight/psum in)
// dn       : downstream link (registered forwards and psum result)
// swap_i   : copy shadow into active buffer
// mode_i   : MODE_PASS / MODE_ACC
// drain_i  : ACC mode, emit accumulator and clear it
// sat_o    : sticky saturation flag
module pe_vec
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned SIGNED     = 1,
  parameter int unsigned SAT        = 1
) (
  input  logic           clk,
  input  logic           rst,
  pe_vec_if.slave        up,
  pe_vec_if.master       dn,
  input  logic           swap_i,
  input  logic           mode_i,
  input  logic           drain_i,
  output logic           sat_o
);

  localparam int unsigned VEC_W  = LANES * DATA_WIDTH;
  localparam int unsigned DOT_W  = dot_width(DATA_WIDTH, LANES);
  localparam logic        SGN    = (SIGNED != 0);
  localparam logic        SAT_EN = (SAT != 0);

  logic [VEC_W-1:0]      shadow_q, shadow_d;
  logic [VEC_W-1:0]      active_q, active_d;
  logic [PSUM_WIDTH-1:0] acc_q, acc_d;
  logic [VEC_W-1:0]      ifmap_o_q, ifmap_o_d;
  logic                  ifmap_en_o_q, ifmap_en_o_d;
  logic [VEC_W-1:0]      weight_o_q, weight_o_d;
  logic                  weight_en_o_q, weight_en_o_d;
  logic [PSUM_WIDTH-1:0] psum_o_q, psum_o_d;
  logic                  psum_en_o_q, psum_en_o_d;
  logic                  sat_q, sat_d;

  logic [DOT_W-1:0]      dot;

  // Dot product always uses the pre-swap active buffer.
  pe_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SIGNED     (SIGNED)
  ) u_dot (
    .a_i   (active_q),
    .b_i   (up.weight),
    .dot_c (dot)
  );

  // Next-state: buffers, forwards, accumulator and psum output.
  always_comb begin
    logic [SUM_W-1:0]      dot_ext;
    logic [SUM_W-1:0]      acc_ext;
    logic [SUM_W-1:0]      psum_ext;
    logic [SUM_W-1:0]      addend;
    sat_res_t              pass_r;
    sat_res_t              acc_r;
    logic [PSUM_WIDTH-1:0] pass_val;
    logic [PSUM_WIDTH-1:0] acc_val;

    dot_ext  = {{(SUM_W-DOT_W){SGN & dot[DOT_W-1]}}, dot};
    acc_ext  = {{(SUM_W-PSUM_WIDTH){SGN & acc_q[PSUM_WIDTH-1]}}, acc_q};
    psum_ext = {{(SUM_W-PSUM_WIDTH){SGN & up.psum[PSUM_WIDTH-1]}}, up.psum};
    addend   = up.weight_en ? dot_ext : '0;
    pass_r   = sat_add(psum_ext, dot_ext, SGN, PSUM_WIDTH);
    acc_r    = sat_add(acc_ext, addend, SGN, PSUM_WIDTH);
    pass_val = SAT_EN ? pass_r.val[PSUM_WIDTH-1:0] : PSUM_WIDTH'(psum_ext + dot_ext);
    acc_val  = SAT_EN ? acc_r.val[PSUM_WIDTH-1:0]  : PSUM_WIDTH'(acc_ext + addend);

    shadow_d      = up.ifmap_en ? up.ifmap : shadow_q;
    active_d      = swap_i ? shadow_q : active_q;
    ifmap_o_d     = up.ifmap_en ? up.ifmap : ifmap_o_q;
    ifmap_en_o_d  = up.ifmap_en;
    weight_o_d    = up.weight_en ? up.weight : weight_o_q;
    weight_en_o_d = up.weight_en;
    acc_d         = acc_q;
    psum_o_d      = psum_o_q;
    psum_en_o_d   = 1'b0;
    sat_d         = sat_q;

    if (mode_i == MODE_ACC) begin
      if (drain_i) begin
        // Drain wins over a simultaneous upstream psum, which is dropped.
        psum_o_d    = acc_val;
        psum_en_o_d = 1'b1;
        acc_d       = '0;
        sat_d       = sat_q | (SAT_EN & acc_r.ovf);
      end else begin
        if (up.weight_en) begin
          acc_d = acc_val;
          sat_d = sat_q | (SAT_EN & acc_r.ovf);
        end
        if (up.psum_en) begin
          psum_o_d    = up.psum;
          psum_en_o_d = 1'b1;
        end
      end
    end else if (up.psum_en) begin
      psum_en_o_d = 1'b1;
      if (up.weight_en) begin
        psum_o_d = pass_val;
        sat_d    = sat_q | (SAT_EN & pass_r.ovf);
      end else begin
        psum_o_d = up.psum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      active_q      <= '0;
      acc_q         <= '0;
      ifmap_o_q     <= '0;
      ifmap_en_o_q  <= 1'b0;
      weight_o_q    <= '0;
      weight_en_o_q <= 1'b0;
      psum_o_q      <= '0;
      psum_en_o_q   <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      acc_q         <= acc_d;
      ifmap_o_q     <= ifmap_o_d;
      ifmap_en_o_q  <= ifmap_en_o_d;
      weight_o_q    <= weight_o_d;
      weight_en_o_q <= weight_en_o_d;
      psum_o_q      <= psum_o_d;
      psum_en_o_q   <= psum_en_o_d;
      sat_q         <= sat_d;
    end
  end

  assign dn.ifmap     = ifmap_o_q;
  assign dn.ifmap_en  = ifmap_en_o_q;
  assign dn.weight    = weight_o_q;
  assign dn.weight_en = weight_en_o_q;
  assign dn.psum      = psum_o_q;
  assign dn.psum_en   = psum_en_o_q;
  assign sat_o        = sat_q;

endmodule
